lc3_mem_arbiter: RTL and testbench
==================================

Name: lc3_mem_arbiter

Overview:
- Arbitrates the single-port LC3 memory between two requesters: the instruction-fetch path of the controller (F) and the load/store data path (D).
- Registers the winning request and drives the memory port until the memory raises its complete signal.
- Returns read data and a one-cycle ack to the winner.
- Sits between the controller/datapath and the memory, replacing direct memory access by the controller.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- TIMEOUT, 15, max ISSUE cycles before abort (used only with MEM_TIMEOUT_EN), range 1..255

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- req_f  in  1  fetch request; held until ack_f
- addr_f  in  ADDR_W  fetch address
- ack_f  out  1  one-cycle fetch completion pulse
- req_d  in  1  data request; held until ack_d
- we_d  in  1  1 = store, 0 = load
- addr_d  in  ADDR_W  data address
- wdata_d  in  DATA_W  store data
- ack_d  out  1  one-cycle data completion pulse
- rdata  out  DATA_W  read data, valid while ack_f or ack_d is high
- err  out  1  access aborted by timeout, valid with ack
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_complete  in  1  memory done; sampled only in ISSUE
- grant_id  out  1  0 = F owns memory, 1 = D owns memory
- state  out  2  current FSM state

Behaviour:
- Reset (reset == 0 at a rising edge):
  - state = IDLE (2'd0).
  - All of mem_en, mem_we, ack_f, ack_d, err, grant_id are 0.
  - mem_addr, mem_wdata and rdata are 0.
  - The round-robin pointer is set to last = D, so F wins the first tie.
  - Reset applies in any state; an in-flight access is dropped with no ack.
- FSM states: IDLE = 0, ISSUE = 1, RESP = 2. Encoding 3 is unused and recovers to IDLE on the next edge.
- IDLE:
  - Only one request pending: that requester wins.
  - Both pending: the requester not granted last wins (round-robin).
  - At the edge, latch the winner's addr (and for D, we/wdata) into the mem_* registers, set grant_id, and go to ISSUE.
  - F accesses always have mem_we = 0.
  - No request pending: stay in IDLE.
- ISSUE:
  - mem_en = 1; mem_we, mem_addr and mem_wdata are held stable.
  - On an edge with mem_complete == 1: capture mem_rdata into rdata (0 for writes), clear mem_en, go to RESP.
  - Otherwise remain in ISSUE.
- RESP:
  - Exactly one of ack_f/ack_d is 1, selected by grant_id.
  - rdata is valid for this cycle.
  - Update the pointer to last = grant_id and go to IDLE.
  - Acks are always single-cycle pulses.
- Handshake: the requester must drop req on the same edge where it samples ack high. A req still high in the IDLE cycle after RESP is treated as a new request.
- Latency: req high before edge 0 → ISSUE in cycle 1. If mem_complete is high in cycle 1, ack is in cycle 2.
  - Minimum req-to-ack latency is 2 cycles.
  - Each additional memory wait cycle adds one.
- Throughput: at most one access per 3 cycles (IDLE, ISSUE, RESP).
- Simultaneous events:
  - A request arriving during ISSUE/RESP waits; it is never lost while held.
  - A change in the losing requester's inputs during ISSUE has no effect on the access in flight.
- mem_complete in IDLE or RESP is ignored.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to ISSUE and increments each ISSUE cycle.
  - If it reaches TIMEOUT with mem_complete still 0, go to RESP with err = 1 and rdata = 0, and clear mem_en.
  - mem_complete on the same edge as timeout wins, giving a normal completion with err = 0.
- MEM_TIMEOUT_EN not defined:
  - ISSUE waits indefinitely.
  - err is tied to 0.
  - No counter logic is present.

Test Plan:
- Reset held low 2 cycles, then released, no requests → state = 0, all outputs 0, mem_en never asserts.
- req_f = 1, addr_f = 16'h3000, mem_complete = 1 immediately, mem_rdata = 16'h1234 → mem_en = 1 in cycle 1, ack_f = 1 with rdata = 16'h1234 in cycle 2, grant_id = 0, single-cycle ack.
- req_d = 1, we_d = 1, addr_d = 16'h4000, wdata_d = 16'hBEEF, mem_complete delayed 3 cycles → mem_we = 1, mem_addr/mem_wdata stable for all 4 ISSUE cycles, ack_d 1 cycle after completion, rdata = 0.
- req_f and req_d both held high for 4 accesses → grants F, D, F, D; acks alternate; no ack overlap.
- Reset driven low during ISSUE of a D access → next cycle state = 0, mem_en = 0, no ack_d; after release with req_d still high, D is re-served.
- MEM_TIMEOUT_EN, TIMEOUT = 15, mem_complete never asserted → mem_en high exactly 15 cycles, then ack with err = 1, rdata = 0. Without the macro, mem_en stays high for 100+ cycles and err stays 0.

Source files
------------

// File: rtl/lc3_mem_arbiter.sv
// Round-robin arbiter sharing the single-port LC3 memory between instruction fetch (F) and
// load/store (D). Define MEM_TIMEOUT_EN to abort accesses that never see mem_complete.
module lc3_mem_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_f,
  input  logic [ADDR_W-1:0] addr_f,
  output logic              ack_f,
  input  logic              req_d,
  input  logic              we_d,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic [DATA_W-1:0] wdata_d,
  output logic              ack_d,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_complete,
  output logic              grant_id,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {StIdle = 2'd0, StIssue = 2'd1, StResp = 2'd2} state_e;

  if (TIMEOUT == 0 || TIMEOUT > 255) begin : g_timeout_range
    $error("TIMEOUT must lie in 1..255");
  end

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              winner;

  // On a tie the requester not served last wins; last_q = 1 means D was served last.
  assign winner = (req_f && req_d) ? ~last_q : req_d;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       timeout;

  assign timeout = (cnt_q == 8'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (req_f || req_d) begin
          state_d    = StIssue;
          grant_d    = winner;
          mem_addr_d = winner ? addr_d : addr_f;
          mem_we_d   = winner & we_d;
          if (winner) begin
            mem_wdata_d = wdata_d;
          end
`ifdef MEM_TIMEOUT_EN
          cnt_d = '0;
          err_d = 1'b0;
`endif
        end
      end
      StIssue: begin
        if (mem_complete) begin
          rdata_d = mem_we_q ? '0 : mem_rdata;
          state_d = StResp;
`ifdef MEM_TIMEOUT_EN
        end else if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      StResp: begin
        last_d  = grant_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StIdle;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign state     = state_q;
  assign mem_en    = (state_q == StIssue);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;
  assign grant_id  = grant_q;
  assign ack_f     = (state_q == StResp) & ~grant_q;
  assign ack_d     = (state_q == StResp) & grant_q;
`ifdef MEM_TIMEOUT_EN
  assign err       = (state_q == StResp) & err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed and randomized bench for lc3_mem_arbiter; the bench itself plays the memory and
// both requesters, predicting every access from the arbitration rules.
module tb_lc3_mem_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        req_f, req_d, we_d, ack_f, ack_d, err;
  logic        mem_en, mem_we, mem_complete, grant_id;
  logic [15:0] addr_f, addr_d, wdata_d, rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  state;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clock = ~clock;

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .req_f(req_f), .addr_f(addr_f), .ack_f(ack_f),
    .req_d(req_d), .we_d(we_d), .addr_d(addr_d), .wdata_d(wdata_d), .ack_d(ack_d),
    .rdata(rdata), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_complete(mem_complete),
    .grant_id(grant_id), .state(state)
  );

  // Reference memory and transaction-level model of the access in flight.
  logic [15:0] ref_mem [8];
  logic        pf, pd, wd;
  logic [15:0] af, ad, wdd;
  int          m_phase;   // 0 idle, 1 memory busy, 2 acknowledging
  int          m_left;    // busy cycles still to go, including the current one
  logic        m_owner, m_last, m_we;
  logic [15:0] m_addr, m_wdata, m_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  function automatic logic [15:0] rand_addr();
    return 16'h3000 + 16'($urandom_range(0, 7));
  endfunction

  initial begin
    int   n;
    logic err_seen;
    logic exp_g;

    reset = 1'b0; req_f = 1'b0; req_d = 1'b0; we_d = 1'b0;
    addr_f = '0; addr_d = '0; wdata_d = '0; mem_complete = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clock);
    tick();

    // Reset values
    chk("rst_state", state, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_ack_f", ack_f, 0);
    chk("rst_ack_d", ack_d, 0);
    chk("rst_err", err, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_mem_en", mem_en, 0);
      chk("idle_state", state, 0);
    end

    // Fetch with immediate completion
    req_f = 1'b1; addr_f = 16'h3000; mem_complete = 1'b1; mem_rdata = 16'h1234;
    tick();
    chk("f_state", state, 1);
    chk("f_mem_en", mem_en, 1);
    chk("f_mem_addr", mem_addr, 16'h3000);
    chk("f_mem_we", mem_we, 0);
    chk("f_ack_early", ack_f, 0);
    tick();
    chk("f_ack", ack_f, 1);
    chk("f_ack_d", ack_d, 0);
    chk("f_rdata", rdata, 16'h1234);
    chk("f_grant", grant_id, 0);
    chk("f_mem_en_off", mem_en, 0);
    req_f = 1'b0; mem_complete = 1'b0;
    tick();
    chk("f_ack_pulse", ack_f, 0);
    chk("f_back_idle", state, 0);

    // Store with three wait cycles
    req_d = 1'b1; we_d = 1'b1; addr_d = 16'h4000; wdata_d = 16'hBEEF; mem_rdata = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("st_state", state, 1);
      chk("st_mem_en", mem_en, 1);
      chk("st_mem_we", mem_we, 1);
      chk("st_mem_addr", mem_addr, 16'h4000);
      chk("st_mem_wdata", mem_wdata, 16'hBEEF);
      chk("st_ack_early", ack_d, 0);
      if (i == 3) mem_complete = 1'b1;
    end
    tick();
    chk("st_ack_d", ack_d, 1);
    chk("st_ack_f", ack_f, 0);
    chk("st_rdata", rdata, 0);
    chk("st_grant", grant_id, 1);
    req_d = 1'b0; we_d = 1'b0; mem_complete = 1'b0;
    tick();
    chk("st_ack_pulse", ack_d, 0);

    // Both held: round-robin F, D, F, D (D was served last)
    req_f = 1'b1; addr_f = 16'h5000; req_d = 1'b1; addr_d = 16'h6000; mem_complete = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_g = k[0];
      chk("rr_idle", state, 0);
      tick();
      chk("rr_grant", grant_id, exp_g);
      chk("rr_addr", mem_addr, exp_g ? 16'h6000 : 16'h5000);
      mem_rdata = 16'hA000 + 16'(k);
      tick();
      chk("rr_ack_f", ack_f, !exp_g);
      chk("rr_ack_d", ack_d, exp_g);
      chk("rr_rdata", rdata, 16'hA000 + 16'(k));
      if (k == 3) begin
        req_f = 1'b0; req_d = 1'b0;
      end
      tick();
    end
    mem_complete = 1'b0;

    // Reset in the middle of a D access, then D re-served
    req_d = 1'b1; we_d = 1'b0; addr_d = 16'h7000;
    tick();
    chk("rs_issue", state, 1);
    reset = 1'b0;
    tick();
    chk("rs_state", state, 0);
    chk("rs_mem_en", mem_en, 0);
    chk("rs_ack_d", ack_d, 0);
    chk("rs_mem_addr", mem_addr, 0);
    reset = 1'b1;
    tick();
    chk("rs_reissue", state, 1);
    chk("rs_regrant", grant_id, 1);
    chk("rs_readdr", mem_addr, 16'h7000);
    mem_complete = 1'b1; mem_rdata = 16'h7777;
    tick();
    chk("rs_ack_d", ack_d, 1);
    chk("rs_rdata", rdata, 16'h7777);
    req_d = 1'b0; mem_complete = 1'b0;
    tick();

    // Memory that never completes
    req_f = 1'b1; addr_f = 16'h8000; mem_rdata = 16'hDEAD;
    n = 0; err_seen = 1'b0;
    tick();
    while (mem_en === 1'b1 && n < 120) begin
      if (err !== 1'b0) err_seen = 1'b1;
      n++;
      tick();
    end
`ifdef MEM_TIMEOUT_EN
    chk("to_len", n, 15);
    chk("to_err_early", err_seen, 0);
    chk("to_ack_f", ack_f, 1);
    chk("to_err", err, 1);
    chk("to_rdata", rdata, 0);
    req_f = 1'b0;
    tick();
    chk("to_err_pulse", err, 0);
    // Completion on the timeout edge is a normal completion
    req_f = 1'b1; addr_f = 16'h3001;
    tick();
    repeat (14) tick();
    mem_complete = 1'b1; mem_rdata = 16'h4321;
    tick();
    chk("tc_ack_f", ack_f, 1);
    chk("tc_err", err, 0);
    chk("tc_rdata", rdata, 16'h4321);
    req_f = 1'b0; mem_complete = 1'b0;
    tick();
`else
    chk("noto_len", n, 120);
    chk("noto_err", err_seen, 0);
    req_f = 1'b0; reset = 1'b0;
    tick();
    chk("noto_rst_state", state, 0);
    chk("noto_rst_mem_en", mem_en, 0);
    reset = 1'b1;
    tick();
`endif

    // Randomized traffic against the reference model
    reset = 1'b0; req_f = 1'b0; req_d = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) ref_mem[i] = 16'($urandom);
    pf = 1'b0; pd = 1'b0; wd = 1'b0; af = '0; ad = '0; wdd = '0;
    m_phase = 0; m_left = 0; m_last = 1'b1; m_owner = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
    for (int c = 0; c < 400; c++) begin
      chk("r_state", state, m_phase);
      chk("r_mem_en", mem_en, m_phase == 1);
      if (m_phase == 1) begin
        chk("r_mem_addr", mem_addr, m_addr);
        chk("r_mem_we", mem_we, m_we);
        if (m_we) chk("r_mem_wdata", mem_wdata, m_wdata);
      end
      chk("r_ack_f", ack_f, m_phase == 2 && !m_owner);
      chk("r_ack_d", ack_d, m_phase == 2 && m_owner);
      if (m_phase == 2) begin
        chk("r_rdata", rdata, m_rdata);
        chk("r_grant", grant_id, m_owner);
        chk("r_err", err, 0);
      end

      // Drive memory and requesters for the coming edge
      if (m_phase == 1) begin
        mem_complete = (m_left == 1);
        mem_rdata = (m_left == 1) ? ref_mem[m_addr[2:0]] : 16'($urandom);
      end else begin
        mem_complete = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
      end
      if (!pf) begin
        if ($urandom_range(0, 2) == 0) begin
          pf = 1'b1; af = rand_addr();
        end
      end else if (!(m_phase != 0 && !m_owner) && $urandom_range(0, 3) == 0) begin
        af = rand_addr();
      end
      if (!pd) begin
        if ($urandom_range(0, 2) == 0) begin
          pd = 1'b1; ad = rand_addr(); wd = 1'($urandom_range(0, 1)); wdd = 16'($urandom);
        end
      end else if (!(m_phase != 0 && m_owner) && $urandom_range(0, 3) == 0) begin
        ad = rand_addr(); wd = 1'($urandom_range(0, 1)); wdd = 16'($urandom);
      end
      req_f = pf; addr_f = af; req_d = pd; addr_d = ad; we_d = wd; wdata_d = wdd;

      @(posedge clock);
      if (m_phase == 0) begin
        if (pf || pd) begin
          m_owner = (pf && pd) ? !m_last : pd;
          m_addr  = m_owner ? ad : af;
          m_we    = m_owner & wd;
          m_wdata = wdd;
          m_left  = $urandom_range(1, 4);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (m_left == 1) begin
          m_rdata = m_we ? 16'h0 : ref_mem[m_addr[2:0]];
          if (m_we) ref_mem[m_addr[2:0]] = m_wdata;
          m_phase = 2;
        end else begin
          m_left--;
        end
      end else begin
        m_last = m_owner;
        if (m_owner) pd = 1'b0;
        else pf = 1'b0;
        m_phase = 0;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
